// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/MEM pipeline stages, the arbiter
// and the single-ported unified memory.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_if;
   logic        stall_mem;
   logic        err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, err
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port, with
// bounded data priority (anti-starvation) and a memory-ready timeout.
module mem_port_arbiter #(
   parameter int MAX_DM_RUN = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic Clk,
   input  logic Reset_n,
   mem_port_arbiter_if.slave bus
);

   localparam int                 WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [2:0]         RUN_MAX   = 3'(MAX_DM_RUN);
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

   state_t             state;
   state_t             nextState;
   logic [2:0]         runCnt;
   logic [WAIT_W-1:0]  waitCnt;
   logic               grantDm;
   logic               errFlag;
   logic               memEn;
   logic               memWe;
   logic [31:0]        memAddr;
   logic [31:0]        memWdata;
   logic [31:0]        ifRdata;
   logic [31:0]        dmRdata;
   logic               ifAck;
   logic               dmAck;
   logic               errOut;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (bus.dm_req && (!bus.if_req || runCnt < RUN_MAX)) nextState = BUSY_DM;
            else if (bus.if_req)                                 nextState = BUSY_IF;
         end
         BUSY_IF, BUSY_DM: begin
            if (bus.mem_ready || waitCnt == WAIT_LAST) nextState = RESP;
         end
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Grant loads the memory strobes; they stay frozen until ready or timeout.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         runCnt   <= '0;
         waitCnt  <= '0;
         grantDm  <= 1'b0;
         errFlag  <= 1'b0;
         memEn    <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWdata <= '0;
         ifRdata  <= '0;
         dmRdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (nextState == BUSY_DM) begin
                  memEn    <= 1'b1;
                  memWe    <= bus.dm_we;
                  memAddr  <= bus.dm_addr;
                  memWdata <= bus.dm_wdata;
                  grantDm  <= 1'b1;
                  waitCnt  <= '0;
                  errFlag  <= 1'b0;
                  if (!bus.if_req)          runCnt <= '0;
                  else if (runCnt < RUN_MAX) runCnt <= runCnt + 3'd1;
               end else if (nextState == BUSY_IF) begin
                  memEn    <= 1'b1;
                  memWe    <= 1'b0;
                  memAddr  <= bus.if_addr;
                  memWdata <= '0;
                  grantDm  <= 1'b0;
                  waitCnt  <= '0;
                  errFlag  <= 1'b0;
                  runCnt   <= '0;
               end else if (!bus.if_req) begin
                  runCnt <= '0;
               end
            end
            BUSY_IF, BUSY_DM: begin
               if (bus.mem_ready) begin
                  memEn <= 1'b0;
                  memWe <= 1'b0;
                  if (grantDm) dmRdata <= bus.mem_rdata;
                  else         ifRdata <= bus.mem_rdata;
               end else begin
                  waitCnt <= waitCnt + WAIT_W'(1);
                  if (waitCnt == WAIT_LAST) begin
                     memEn   <= 1'b0;
                     memWe   <= 1'b0;
                     errFlag <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ifAck  = (state == RESP) && !grantDm;
      dmAck  = (state == RESP) && grantDm;
      errOut = (state == RESP) && errFlag;
   end

   assign bus.if_ack    = ifAck;
   assign bus.dm_ack    = dmAck;
   assign bus.err       = errOut;
   assign bus.if_rdata  = ifRdata;
   assign bus.dm_rdata  = dmRdata;
   assign bus.mem_en    = memEn;
   assign bus.mem_we    = memWe;
   assign bus.mem_addr  = memAddr;
   assign bus.mem_wdata = memWdata;
   assign bus.stall_if  = bus.if_req & ~ifAck;
   assign bus.stall_mem = bus.dm_req & ~dmAck;

endmodule
